// File: rtl/internal_framebuffer_stream_loader.sv
// Loads an AXI-Stream of pixel beats into an internal framebuffer RAM, one word per beat,
// masking sub pixels by strobe, the configured write mask and an optional scissor rectangle.
module internal_framebuffer_stream_loader #(
   parameter int unsigned NUMBER_OF_PIXELS_PER_BEAT    = 2,
   parameter int unsigned NUMBER_OF_SUB_PIXELS         = 4,
   parameter int unsigned SUB_PIXEL_WIDTH              = 8,
   parameter int unsigned X_BIT_WIDTH                  = 11,
   parameter int unsigned Y_BIT_WIDTH                  = 11,
   parameter int unsigned FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
   localparam int unsigned MW = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS,
   localparam int unsigned DW = MW * SUB_PIXEL_WIDTH,
   localparam int unsigned AW = FRAMEBUFFER_SIZE_IN_PIXEL_LG - $clog2(NUMBER_OF_PIXELS_PER_BEAT)
) (
   input  logic                                  aclk,
   input  logic                                  resetn,
   input  logic                                  confEnableScissor,
   input  logic [X_BIT_WIDTH-1:0]                confScissorStartX,
   input  logic [Y_BIT_WIDTH-1:0]                confScissorStartY,
   input  logic [X_BIT_WIDTH-1:0]                confScissorEndX,
   input  logic [Y_BIT_WIDTH-1:0]                confScissorEndY,
   input  logic [X_BIT_WIDTH-1:0]                confXResolution,
   input  logic [Y_BIT_WIDTH-1:0]                confYResolution,
   input  logic [NUMBER_OF_SUB_PIXELS-1:0]       confMask,
   input  logic                                  apply,
   output logic                                  applied,
   input  logic                                  cmdLoad,
   input  logic [FRAMEBUFFER_SIZE_IN_PIXEL_LG:0] cmdSize,
   input  logic                                  s_axis_tvalid,
   output logic                                  s_axis_tready,
   input  logic                                  s_axis_tlast,
   input  logic [DW-1:0]                         s_axis_tdata,
   input  logic [MW-1:0]                         s_axis_tstrb,
   output logic                                  writeEnablePort,
   output logic [AW-1:0]                         writeAddrPort,
   output logic [DW-1:0]                         writeDataPort,
   output logic [MW-1:0]                         writeMaskPort
);

   localparam int unsigned BEAT_LG = $clog2(NUMBER_OF_PIXELS_PER_BEAT);
   localparam int unsigned CW      = FRAMEBUFFER_SIZE_IN_PIXEL_LG + 1;
   localparam int unsigned XW      = X_BIT_WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

   state_e                r_state, w_state_next;
   logic [CW-1:0]         r_beats;
   logic [AW-1:0]         r_idx;
   logic [X_BIT_WIDTH-1:0] r_x;
   logic [Y_BIT_WIDTH-1:0] r_y;
   logic                  r_applied, r_tready, r_we;
   logic [AW-1:0]         r_addr;
   logic [DW-1:0]         r_data;
   logic [MW-1:0]         r_mask;

   logic                  w_accept, w_last_beat, w_x_wrap;
   logic [CW-1:0]         w_cmd_beats;
   logic [XW-1:0]         w_x_sum, w_px;
   logic                  w_in, w_applied_d, w_tready_d, w_we_d;
   logic [MW-1:0]         w_mask_d;

   assign w_accept    = s_axis_tvalid & r_tready;
   assign w_cmd_beats = cmdSize >> BEAT_LG;
   assign w_last_beat = (CW'(r_idx) + CW'(1)) == r_beats;
   assign w_x_sum     = {1'b0, r_x} + XW'(NUMBER_OF_PIXELS_PER_BEAT);
   assign w_x_wrap    = w_x_sum == {1'b0, confXResolution};

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         r_state   <= StIdle;
         r_applied <= 1'b1;
         r_tready  <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_mask    <= '0;
         r_beats   <= '0;
         r_idx     <= '0;
         r_x       <= '0;
         r_y       <= '0;
      end else begin
         r_state   <= w_state_next;
         r_applied <= w_applied_d;
         r_tready  <= w_tready_d;
         r_we      <= w_we_d;
         if (w_we_d) begin
            r_addr <= r_idx;
            r_data <= s_axis_tdata;
            r_mask <= w_mask_d;
         end
         // Command parameters are sampled continuously while idle, so the apply cycle wins.
         if (r_state == StIdle) begin
            r_beats <= w_cmd_beats;
            r_idx   <= '0;
            r_x     <= '0;
            r_y     <= confYResolution - Y_BIT_WIDTH'(1);
         end else if (w_we_d) begin
            r_idx <= r_idx + AW'(1);
            if (w_x_wrap) begin
               r_x <= '0;
               r_y <= r_y - Y_BIT_WIDTH'(1);
            end else begin
               r_x <= w_x_sum[X_BIT_WIDTH-1:0];
            end
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (apply && cmdLoad) begin
               w_state_next = (w_cmd_beats == '0) ? StDrain : StLoad;
            end
         end
         StLoad: begin
            if (w_accept) begin
               if (s_axis_tlast) begin
                  w_state_next = StIdle;
               end else if (w_last_beat) begin
                  w_state_next = StDrain;
               end
            end
         end
         StDrain: begin
            if (w_accept && s_axis_tlast) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      w_applied_d = (w_state_next == StIdle);
      w_tready_d  = (w_state_next != StIdle);
      w_we_d      = (r_state == StLoad) && w_accept;
      w_mask_d    = '0;
      w_px        = '0;
      w_in        = 1'b0;
      for (int i = 0; i < int'(NUMBER_OF_PIXELS_PER_BEAT); i++) begin
         w_px = {1'b0, r_x} + XW'(i);
         w_in = !confEnableScissor ||
                ((w_px >= {1'b0, confScissorStartX}) && (w_px < {1'b0, confScissorEndX}) &&
                 (r_y >= confScissorStartY) && (r_y < confScissorEndY));
         w_mask_d[i*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] =
            s_axis_tstrb[i*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] & confMask &
            {NUMBER_OF_SUB_PIXELS{w_in}};
      end
   end

   assign applied         = r_applied;
   assign s_axis_tready   = r_tready;
   assign writeEnablePort = r_we;
   assign writeAddrPort   = r_addr;
   assign writeDataPort   = r_data;
   assign writeMaskPort   = r_mask;

endmodule

// File: tb/tb_internal_framebuffer_stream_loader.sv
// Directed bench for internal_framebuffer_stream_loader: a table of beats with expected RAM
// writes, applied under several configurations, plus hand sequences for reset and early end.
module tb_internal_framebuffer_stream_loader;

   logic        aclk = 1'b0;
   logic        resetn;
   logic        confEnableScissor;
   logic [10:0] confScissorStartX, confScissorEndX, confXResolution;
   logic [10:0] confScissorStartY, confScissorEndY, confYResolution;
   logic [3:0]  confMask;
   logic        apply, applied, cmdLoad;
   logic [18:0] cmdSize;
   logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tstrb;
   logic        writeEnablePort;
   logic [16:0] writeAddrPort;
   logic [63:0] writeDataPort;
   logic [7:0]  writeMaskPort;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 aclk = ~aclk;

   internal_framebuffer_stream_loader dut (
      .aclk              (aclk),
      .resetn            (resetn),
      .confEnableScissor (confEnableScissor),
      .confScissorStartX (confScissorStartX),
      .confScissorStartY (confScissorStartY),
      .confScissorEndX   (confScissorEndX),
      .confScissorEndY   (confScissorEndY),
      .confXResolution   (confXResolution),
      .confYResolution   (confYResolution),
      .confMask          (confMask),
      .apply             (apply),
      .applied           (applied),
      .cmdLoad           (cmdLoad),
      .cmdSize           (cmdSize),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tready     (s_axis_tready),
      .s_axis_tlast      (s_axis_tlast),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tstrb      (s_axis_tstrb),
      .writeEnablePort   (writeEnablePort),
      .writeAddrPort     (writeAddrPort),
      .writeDataPort     (writeDataPort),
      .writeMaskPort     (writeMaskPort)
   );

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
      int          gap;
      logic        exp_wr;
      logic [16:0] exp_addr;
      logic [7:0]  exp_mask;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input int id, input logic [7:0] strb, input logic last,
                               input int gap, input logic wr, input int addr,
                               input logic [7:0] mask);
      vec_t v;
      v.data     = 64'h0123_4567_89AB_0000 + 64'(id) * 64'h0001_0001_0001_0011;
      v.strb     = strb;
      v.last     = last;
      v.gap      = gap;
      v.exp_wr   = wr;
      v.exp_addr = 17'(addr);
      v.exp_mask = mask;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the beat was accepted.
   task automatic send(input int k);
      vec_t v = vt[k];
      int   n = 0;
      s_axis_tvalid = 1'b0;
      for (int g = 0; g < v.gap; g++) begin
         @(negedge aclk);
         check($sformatf("gap_no_write[%0d]", k), 64'(writeEnablePort), 64'd0);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = v.data;
      s_axis_tstrb  = v.strb;
      s_axis_tlast  = v.last;
      while (s_axis_tready !== 1'b1 && n < 50) begin
         @(negedge aclk);
         n++;
      end
      if (s_axis_tready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout[%0d]: tready=%b, expected 1", k, s_axis_tready);
         s_axis_tvalid = 1'b0;
      end else begin
         @(negedge aclk);
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
         check($sformatf("wr_en[%0d]", k), 64'(writeEnablePort), 64'(v.exp_wr));
         if (v.exp_wr) begin
            check($sformatf("wr_addr[%0d]", k), 64'(writeAddrPort), 64'(v.exp_addr));
            check($sformatf("wr_mask[%0d]", k), 64'(writeMaskPort), 64'(v.exp_mask));
            check($sformatf("wr_data[%0d]", k), writeDataPort, v.data);
         end
      end
   endtask

   task automatic run(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) send(k);
   endtask

   task automatic do_apply(input logic [18:0] size);
      apply   = 1'b1;
      cmdLoad = 1'b1;
      cmdSize = size;
      @(negedge aclk);
      apply   = 1'b0;
      cmdLoad = 1'b0;
      check("applied_low_after_apply", 64'(applied), 64'd0);
      check("tready_after_apply", 64'(s_axis_tready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Full load, 4 beats at xres=4/yres=2
      for (int i = 0; i < 4; i++) vt.push_back(mk(i, 8'hFF, i == 3, 0, 1'b1, i, 8'hFF));
      // Scissor X 2..4, Y 0..1: only the right half of the bottom line (y=0) survives
      vt.push_back(mk(4, 8'hFF, 1'b0, 0, 1'b1, 0, 8'h00));
      vt.push_back(mk(5, 8'hFF, 1'b0, 0, 1'b1, 1, 8'h00));
      vt.push_back(mk(6, 8'hFF, 1'b0, 0, 1'b1, 2, 8'h00));
      vt.push_back(mk(7, 8'hFF, 1'b1, 0, 1'b1, 3, 8'hFF));
      // Early tlast on beat 2 of 4
      vt.push_back(mk(8, 8'hFF, 1'b0, 0, 1'b1, 0, 8'hFF));
      vt.push_back(mk(9, 8'hFF, 1'b1, 0, 1'b1, 1, 8'hFF));
      // Overlong: 2 beats written, 3 drained
      vt.push_back(mk(10, 8'hFF, 1'b0, 0, 1'b1, 0, 8'hFF));
      vt.push_back(mk(11, 8'hFF, 1'b0, 0, 1'b1, 1, 8'hFF));
      vt.push_back(mk(12, 8'hFF, 1'b0, 0, 1'b0, 0, 8'h00));
      vt.push_back(mk(13, 8'hFF, 1'b0, 1, 1'b0, 0, 8'h00));
      vt.push_back(mk(14, 8'hFF, 1'b1, 0, 1'b0, 0, 8'h00));
      // confMask=0001 with tstrb=F0 and valid gaps
      vt.push_back(mk(15, 8'hF0, 1'b0, 2, 1'b1, 0, 8'h10));
      vt.push_back(mk(16, 8'hF0, 1'b1, 3, 1'b1, 1, 8'h10));
      // One beat before reset, then a fresh load
      vt.push_back(mk(17, 8'hFF, 1'b0, 0, 1'b1, 0, 8'hFF));
      vt.push_back(mk(18, 8'hFF, 1'b0, 0, 1'b1, 0, 8'hFF));
      vt.push_back(mk(19, 8'hFF, 1'b1, 0, 1'b1, 1, 8'hFF));

      resetn            = 1'b0;
      confEnableScissor = 1'b0;
      confScissorStartX = 11'd0;
      confScissorStartY = 11'd0;
      confScissorEndX   = 11'd0;
      confScissorEndY   = 11'd0;
      confXResolution   = 11'd4;
      confYResolution   = 11'd2;
      confMask          = 4'hF;
      apply             = 1'b0;
      cmdLoad           = 1'b0;
      cmdSize           = '0;
      s_axis_tvalid     = 1'b0;
      s_axis_tlast      = 1'b0;
      s_axis_tdata      = '0;
      s_axis_tstrb      = '0;

      repeat (3) @(negedge aclk);
      check("rst_applied", 64'(applied), 64'd1);
      check("rst_tready", 64'(s_axis_tready), 64'd0);
      check("rst_we", 64'(writeEnablePort), 64'd0);
      check("rst_addr", 64'(writeAddrPort), 64'd0);
      check("rst_data", writeDataPort, 64'd0);
      check("rst_mask", 64'(writeMaskPort), 64'd0);
      resetn = 1'b1;
      @(negedge aclk);
      check("we_after_reset_release", 64'(writeEnablePort), 64'd0);
      check("applied_idle", 64'(applied), 64'd1);

      // apply without cmdLoad does nothing
      apply   = 1'b1;
      cmdSize = 19'd8;
      @(negedge aclk);
      apply = 1'b0;
      check("apply_no_load_applied", 64'(applied), 64'd1);
      check("apply_no_load_tready", 64'(s_axis_tready), 64'd0);

      do_apply(19'd8);
      run(0, 3);
      check("full_applied_after", 64'(applied), 64'd1);
      check("full_tready_after", 64'(s_axis_tready), 64'd0);

      confEnableScissor = 1'b1;
      confScissorStartX = 11'd2;
      confScissorEndX   = 11'd4;
      confScissorStartY = 11'd0;
      confScissorEndY   = 11'd1;
      do_apply(19'd8);
      run(4, 7);
      check("scissor_applied_after", 64'(applied), 64'd1);
      confEnableScissor = 1'b0;

      do_apply(19'd8);
      run(8, 9);
      check("early_applied_after", 64'(applied), 64'd1);
      s_axis_tvalid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge aclk);
         check($sformatf("early_no_tready[%0d]", c), 64'(s_axis_tready), 64'd0);
         check($sformatf("early_no_write[%0d]", c), 64'(writeEnablePort), 64'd0);
      end
      s_axis_tvalid = 1'b0;

      do_apply(19'd4);
      run(10, 11);
      check("drain_applied", 64'(applied), 64'd0);
      check("drain_tready", 64'(s_axis_tready), 64'd1);
      run(12, 14);
      check("overlong_applied_after", 64'(applied), 64'd1);
      check("overlong_tready_after", 64'(s_axis_tready), 64'd0);

      confMask = 4'b0001;
      do_apply(19'd4);
      run(15, 16);
      confMask = 4'hF;
      check("mask_applied_after", 64'(applied), 64'd1);

      do_apply(19'd8);
      run(17, 17);
      resetn = 1'b0;
      @(negedge aclk);
      check("midrst_tready", 64'(s_axis_tready), 64'd0);
      check("midrst_applied", 64'(applied), 64'd1);
      check("midrst_we", 64'(writeEnablePort), 64'd0);
      check("midrst_addr", 64'(writeAddrPort), 64'd0);
      check("midrst_mask", 64'(writeMaskPort), 64'd0);
      check("midrst_data", writeDataPort, 64'd0);
      resetn = 1'b1;
      @(negedge aclk);
      check("midrst_release_we", 64'(writeEnablePort), 64'd0);
      do_apply(19'd4);
      run(18, 19);
      check("restart_applied_after", 64'(applied), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/internal_framebuffer_stream_loader.md
INTERNAL_FRAMEBUFFER_STREAM_LOADER -- requirements
Module: internal_framebuffer_stream_loader

Interface
REQ-001 SHALL have parameter NUMBER_OF_PIXELS_PER_BEAT, default 2, pixels per stream beat/memory word (power of two).
REQ-002 SHALL have parameter NUMBER_OF_SUB_PIXELS, default 4, sub pixels per pixel.
REQ-003 SHALL have parameter SUB_PIXEL_WIDTH, default 8, bits per sub pixel.
REQ-004 SHALL have parameter X_BIT_WIDTH, default 11, x coordinate width.
REQ-005 SHALL have parameter Y_BIT_WIDTH, default 11, y coordinate width.
REQ-006 SHALL have parameter FRAMEBUFFER_SIZE_IN_PIXEL_LG, default 18, log2 of memory size in pixels; derived: PW=NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH, MW=NUMBER_OF_PIXELS_PER_BEAT*NUMBER_OF_SUB_PIXELS, DW=MW*SUB_PIXEL_WIDTH, AW=FRAMEBUFFER_SIZE_IN_PIXEL_LG-log2(NUMBER_OF_PIXELS_PER_BEAT).
REQ-007 SHALL have aclk  input  1  clock, all logic on rising edge.
REQ-008 SHALL have resetn  input  1  reset, synchronous, active-low.
REQ-009 SHALL have confEnableScissor  input  1  enables scissor masking.
REQ-010 SHALL have confScissorStartX  input  X_BIT_WIDTH  inclusive scissor x start.
REQ-011 SHALL have confScissorStartY  input  Y_BIT_WIDTH  inclusive scissor y start.
REQ-012 SHALL have confScissorEndX  input  X_BIT_WIDTH  exclusive scissor x end.
REQ-013 SHALL have confScissorEndY  input  Y_BIT_WIDTH  exclusive scissor y end.
REQ-014 SHALL have confXResolution  input  X_BIT_WIDTH  line width in pixels, multiple of NUMBER_OF_PIXELS_PER_BEAT.
REQ-015 SHALL have confYResolution  input  Y_BIT_WIDTH  number of lines.
REQ-016 SHALL have confMask  input  NUMBER_OF_SUB_PIXELS  per-sub-pixel write enable.
REQ-017 SHALL have apply  input  1  start command.
REQ-018 SHALL have applied  output  1  high when idle and no command pending.
REQ-019 SHALL have cmdLoad  input  1  selects stream-to-memory load.
REQ-020 SHALL have cmdSize  input  FRAMEBUFFER_SIZE_IN_PIXEL_LG+1  load size in pixels.
REQ-021 SHALL have s_axis_tvalid / s_axis_tready / s_axis_tlast  input/output/input  1 each  AXIS slave handshake.
REQ-022 SHALL have s_axis_tdata  input  DW  pixel data, pixel 0 in LSBs.
REQ-023 SHALL have s_axis_tstrb  input  MW  per-sub-pixel strobe.
REQ-024 SHALL have writeEnablePort / writeAddrPort  output  1 / AW  RAM write strobe and word address.
REQ-025 SHALL have writeDataPort / writeMaskPort  output  DW / MW  RAM write data and sub-pixel mask.

Function
REQ-026 SHALL implement states IDLE, LOAD, DRAIN; IDLE latches beats=cmdSize>>log2(NUMBER_OF_PIXELS_PER_BEAT), idx=0, x=0, y=confYResolution-1.
REQ-027 SHALL, in IDLE with apply&cmdLoad, drive applied=0 next cycle and enter LOAD (DRAIN if beats==0); apply without cmdLoad ignored; applied=1 in IDLE when apply low.
REQ-028 SHALL drive s_axis_tready=1 registered in LOAD and DRAIN only, 0 otherwise; no backpressure otherwise.
REQ-029 SHALL, per accepted beat in LOAD, register writeEnablePort=1, writeAddrPort=idx, writeDataPort=tdata, writeMaskPort=tstrb & {NUMBER_OF_PIXELS_PER_BEAT{confMask}} & scissor mask; latency 1 cycle; writeEnablePort=0 in cycles without acceptance.
REQ-030 SHALL compute per pixel i scissor bit = !confEnableScissor or (StartX<=x+i<EndX and StartY<=y<EndY), replicated over its sub pixels.
REQ-031 SHALL per accepted beat increment idx (mod 2^AW), x+=NUMBER_OF_PIXELS_PER_BEAT; at x+NUMBER_OF_PIXELS_PER_BEAT==confXResolution set x=0, y=y-1 (wrap mod 2^Y_BIT_WIDTH).
REQ-032 SHALL end LOAD on accepted beat with tlast (early end, written) -> IDLE; beat with idx+1==beats and no tlast -> DRAIN; both -> IDLE.
REQ-033 SHALL in DRAIN accept and discard beats (no writes) until tlast accepted, then IDLE.
REQ-034 SHALL ignore apply while LOAD/DRAIN.

Reset
REQ-035 SHALL on resetn low (including mid-LOAD/DRAIN) enter IDLE next edge: applied=1, s_axis_tready=0, writeEnablePort=0, writeAddrPort=0, writeDataPort=0, writeMaskPort=0.
REQ-036 SHALL not write RAM in the cycle after reset deasserts.

Verification
REQ-037 SHALL test full load: defaults, confXResolution=4, confYResolution=2, cmdSize=8, 4 beats, tlast on 4th -> writes addr 0..3, masks 0xFF, applied=1 after.
REQ-038 SHALL test scissor: enabled, X 2..4, Y 0..1, same frame -> addr 0,1 (y=1) mask 0x00, addr 2 mask 0x00, addr 3 mask 0xFF.
REQ-039 SHALL test early tlast on beat 2 of cmdSize=8 -> 2 writes, IDLE, no further tready.
REQ-040 SHALL test overlong stream: cmdSize=4, 5 beats tlast on 5th -> writes addr 0,1 only, 3 beats drained.
REQ-041 SHALL test confMask=4'b0001, tstrb=0xF0, valid gaps -> writeMaskPort=0x10, writes only on accepted beats.
REQ-042 SHALL test resetn low after 1 beat of 4 -> tready=0, applied=1, next load restarts at addr 0.
